// File: rtl/aes_avalon_host_master.sv
// aes_avalon_host_master
//   Avalon-MM initiator that runs the AES accelerator's command/status/data
//   register protocol for one 128-bit block at a time. The block comes in on a
//   valid/ready stream and the result leaves on a valid/ready stream.
//
// Build option:
//   AES_HOST_AUTOSTART_EN - when defined, a START command (write 3 to addr 1)
//   is issued once after reset before the first block is accepted.
//
// Parameters:
//   POLL_LIMIT   max status reads per poll phase before giving up (0 = unlimited)
//
// Ports:
//   clock, resetn            rising-edge clock, synchronous active-low reset
//   in_valid/in_ready        input block handshake (in_ready only in IDLE)
//   in_block[127:0]          block, [127:96] sent first
//   out_valid/out_ready      result handshake, result held until taken
//   out_block[127:0]         result, [127:96] from addr 4
//   err                      one-cycle pulse on poll timeout
//   busy                     high whenever not IDLE
//   avm_*                    Avalon-MM initiator, zero read latency
module aes_avalon_host_master #(
  parameter int POLL_LIMIT = 1024
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_block,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_block,
  output logic         err,
  output logic         busy,
  output logic [7:0]   avm_address,
  output logic         avm_chipselect,
  output logic         avm_read,
  output logic         avm_write,
  output logic [31:0]  avm_writedata,
  input  logic [31:0]  avm_readdata,
  input  logic         avm_waitrequest
);

  localparam int CW = (POLL_LIMIT > 0) ? $clog2(POLL_LIMIT + 1) : 1;
  localparam logic [CW:0] LIMIT_V = (CW+1)'(POLL_LIMIT);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_XFER   = 3'd1;
  localparam logic [2:0] S_GAP    = 3'd2;
  localparam logic [2:0] S_OUTPUT = 3'd3;
  localparam logic [2:0] S_START  = 3'd4;

`ifdef AES_HOST_AUTOSTART_EN
  localparam logic [2:0] S_RESET = S_START;
`else
  localparam logic [2:0] S_RESET = S_IDLE;
`endif

  // Transaction steps within one block; ERR_CLR is the status clear that
  // follows a poll timeout.
  localparam logic [3:0] ST_CMD_IN   = 4'd0;
  localparam logic [3:0] ST_WR0      = 4'd1;
  localparam logic [3:0] ST_WR3      = 4'd4;
  localparam logic [3:0] ST_POLL_IN  = 4'd5;
  localparam logic [3:0] ST_CLR_IN   = 4'd6;
  localparam logic [3:0] ST_CMD_OUT  = 4'd7;
  localparam logic [3:0] ST_POLL_OUT = 4'd8;
  localparam logic [3:0] ST_RD0      = 4'd9;
  localparam logic [3:0] ST_RD3      = 4'd12;
  localparam logic [3:0] ST_CLR_OUT  = 4'd13;
  localparam logic [3:0] ST_ERR_CLR  = 4'd14;

  logic [2:0]       state_q;
  logic [2:0]       after_gap_q;
  logic [3:0]       step_q;
  logic [3:0][31:0] blk_q;
  logic [3:0][31:0] res_q;
  logic [CW-1:0]    cnt_q;
  logic             err_q;
  logic             rst_done_q;

  logic        req_wr;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        act, done, is_poll, is_rd, timeout_hit;

  always_comb begin
    req_wr    = 1'b0;
    req_addr  = 8'd0;
    req_wdata = 32'd0;
    if (state_q == S_START) begin
      req_wr = 1'b1; req_addr = 8'd1; req_wdata = 32'd3;
    end else begin
      case (step_q)
        ST_CMD_IN: begin req_wr = 1'b1; req_addr = 8'd1; req_wdata = 32'd1; end
        4'd1, 4'd2, 4'd3, 4'd4: begin
          // WR0 sends blk_q[3] (bits 127:96), WR3 sends blk_q[0]
          req_wr = 1'b1; req_addr = 8'd3; req_wdata = blk_q[2'(4'd4 - step_q)];
        end
        ST_POLL_IN, ST_POLL_OUT: req_addr = 8'd2;
        ST_CLR_IN, ST_CLR_OUT, ST_ERR_CLR: begin req_wr = 1'b1; req_addr = 8'd2; end
        ST_CMD_OUT: begin req_wr = 1'b1; req_addr = 8'd1; req_wdata = 32'd2; end
        4'd9, 4'd10, 4'd11, 4'd12: req_addr = 8'd4 + {4'd0, step_q - ST_RD0};
        default: ;
      endcase
    end
  end

  // rst_done_q keeps every output quiet on the reset edge itself and on the
  // cycle after it when START_CMD is the reset state.
  assign act            = rst_done_q && ((state_q == S_XFER) || (state_q == S_START));
  assign done           = act && !avm_waitrequest;
  assign is_poll        = (step_q == ST_POLL_IN) || (step_q == ST_POLL_OUT);
  assign is_rd          = (step_q >= ST_RD0) && (step_q <= ST_RD3);
  assign timeout_hit    = (POLL_LIMIT != 0) && (({1'b0, cnt_q} + (CW+1)'(1)) == LIMIT_V);

  assign avm_chipselect = act;
  assign avm_read       = act && !req_wr;
  assign avm_write      = act && req_wr;
  assign avm_address    = act ? req_addr : 8'd0;
  assign avm_writedata  = act ? req_wdata : 32'd0;

  assign in_ready  = rst_done_q && (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_OUTPUT);
  assign out_block = res_q;
  assign err       = err_q;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q     <= S_RESET;
      after_gap_q <= S_IDLE;
      step_q      <= ST_CMD_IN;
      blk_q       <= '0;
      res_q       <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      rst_done_q  <= 1'b0;
    end else begin
      rst_done_q <= 1'b1;
      err_q      <= 1'b0;
      case (state_q)
        S_IDLE: if (in_valid && in_ready) begin
          blk_q   <= in_block;
          step_q  <= ST_CMD_IN;
          state_q <= S_XFER;
        end
        S_START: if (done) begin
          state_q     <= S_GAP;
          after_gap_q <= S_IDLE;
        end
        S_XFER: if (done) begin
          state_q     <= S_GAP;
          after_gap_q <= S_XFER;
          if (is_poll) begin
            // failed poll repeats the same step after its GAP
            if (avm_readdata[0]) begin
              step_q <= step_q + 4'd1;
            end else begin
              if (POLL_LIMIT != 0) cnt_q <= cnt_q + CW'(1);
              if (timeout_hit) begin
                err_q  <= 1'b1;
                step_q <= ST_ERR_CLR;
              end
            end
          end else begin
            cnt_q <= '0;
            if (is_rd) res_q[2'(ST_RD3 - step_q)] <= avm_readdata;
            case (step_q)
              ST_CLR_OUT: after_gap_q <= S_OUTPUT;
              ST_ERR_CLR: after_gap_q <= S_IDLE;
              default:    step_q      <= step_q + 4'd1;
            endcase
          end
        end
        S_GAP:    state_q <= after_gap_q;
        S_OUTPUT: if (out_ready) state_q <= S_IDLE;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_avalon_host_master.sv
// Bench for aes_avalon_host_master: randomized blocks against an Avalon
// responder model, with a transaction-list model of the expected bus traffic
// and a timing model (2 cycles per transaction plus stall cycles).
module tb_aes_avalon_host_master;
  localparam int LIMIT = 4;
`ifdef AES_HOST_AUTOSTART_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic         clock = 1'b0, resetn = 1'b0;
  logic         in_valid = 1'b0, in_ready;
  logic [127:0] in_block = '0, out_block;
  logic         out_valid, out_ready = 1'b0, err, busy;
  logic [7:0]   avm_address;
  logic         avm_chipselect, avm_read, avm_write;
  logic [31:0]  avm_writedata, avm_readdata;
  logic         avm_waitrequest = 1'b0;

  aes_avalon_host_master #(.POLL_LIMIT(LIMIT)) dut (
    .clock(clock), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready), .in_block(in_block),
    .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block),
    .err(err), .busy(busy),
    .avm_address(avm_address), .avm_chipselect(avm_chipselect),
    .avm_read(avm_read), .avm_write(avm_write), .avm_writedata(avm_writedata),
    .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest)
  );

  always #5 clock = ~clock;

  int vectors = 0, miscompares = 0;

  task automatic check(input string nm, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  task automatic fail(input string nm);
    vectors++;
    miscompares++;
    $display("FAIL %s", nm);
  endtask

  // ---------------- responder model ----------------
  logic [31:0] mem [0:3];
  int  zeros_left = 0, plan_in = 0, plan_out = 0;
  bit  rand_wait = 1'b0, stall_en = 1'b0;
  int  stall_cnt = 0;
  localparam logic [31:0] STALL_DATA = 32'h8899AABB;

  // upper status bits carry junk the DUT must ignore
  always_comb begin
    if (avm_address == 8'd2)
      avm_readdata = {31'h5EADBEE7, zeros_left == 0};
    else if (avm_address >= 8'd4 && avm_address <= 8'd7)
      avm_readdata = mem[avm_address[1:0]];
    else
      avm_readdata = 32'h0;
  end

  always @(posedge clock) begin
    if (avm_chipselect && !avm_waitrequest) begin
      if (avm_write && avm_address == 8'd1 && avm_writedata == 32'd1) zeros_left <= plan_in;
      else if (avm_write && avm_address == 8'd1 && avm_writedata == 32'd2) zeros_left <= plan_out;
      else if (avm_read && avm_address == 8'd2 && zeros_left > 0) zeros_left <= zeros_left - 1;
    end
    #1;
    if (stall_en && avm_write && avm_address == 8'd3 && avm_writedata == STALL_DATA && stall_cnt < 3) begin
      avm_waitrequest = 1'b1;
      stall_cnt++;
    end else begin
      avm_waitrequest = rand_wait && ($urandom_range(0, 3) == 0);
    end
  end

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] data;
    logic        last_err;
  } tx_t;

  tx_t          exp_q[$];
  bit           rst_ok = 1'b0, active = 1'b0, is_normal = 1'b0;
  int           cyc = 0, acc_cyc = 0, n_tx = 0, waits = 0, acc_cnt = 0;
  logic [127:0] exp_res = '0;
  bit           gap_exp = 1'b0, err_exp = 1'b0, held = 1'b0;
  tx_t          held_tx;
  // per-block statistics for the literal checks
  int           stat_reads = 0, err_cnt = 0, ov_rise = -1;
  bit           ov_prev = 1'b0;
  logic [31:0]  wr3_q[$];
  tx_t          last_tx;

  task automatic push(input bit wr, input int addr, input logic [31:0] d, input bit e);
    tx_t t;
    t.wr = wr; t.addr = 8'(addr); t.data = d; t.last_err = e;
    exp_q.push_back(t);
  endtask

  task automatic push_poll(input int zeros, output bit to);
    int n;
    to = (zeros >= LIMIT);
    n  = to ? LIMIT : zeros + 1;
    for (int i = 0; i < n; i++) push(1'b0, 2, 32'd0, to && (i == n - 1));
  endtask

  task automatic build(input logic [127:0] b);
    bit to;
    exp_q.delete();
    push(1'b1, 1, 32'd1, 1'b0);
    for (int k = 0; k < 4; k++) push(1'b1, 3, b[127 - 32*k -: 32], 1'b0);
    push_poll(plan_in, to);
    is_normal = 1'b0;
    push(1'b1, 2, 32'd0, 1'b0);
    if (!to) begin
      push(1'b1, 1, 32'd2, 1'b0);
      push_poll(plan_out, to);
      if (!to) begin
        for (int k = 0; k < 4; k++) push(1'b0, 4 + k, 32'd0, 1'b0);
        is_normal = 1'b1;
      end
      push(1'b1, 2, 32'd0, 1'b0);
    end
    n_tx    = exp_q.size();
    exp_res = {mem[0], mem[1], mem[2], mem[3]};
    stat_reads = 0; err_cnt = 0; ov_rise = -1; wr3_q.delete();
  endtask

  always @(posedge clock) begin
    int old;
    old = cyc;
    cyc++;
    if (!resetn) begin
      rst_ok = 1'b0; active = 1'b0; exp_q.delete();
      gap_exp = 1'b0; err_exp = 1'b0; held = 1'b0;
    end else if (!rst_ok) begin
      rst_ok = 1'b1;
      if (AUTO) begin
        exp_q.delete();
        push(1'b1, 1, 32'd3, 1'b0);
        n_tx = 1; is_normal = 1'b0; active = 1'b1; acc_cyc = cyc; waits = 0;
      end
    end else if (active) begin
      if (is_normal && old >= acc_cyc + 2*n_tx + waits && out_ready) active = 1'b0;
      else if (!is_normal && cyc >= acc_cyc + 2*n_tx + waits) active = 1'b0;
    end else if (in_valid) begin
      build(in_block);
      active = 1'b1; acc_cyc = cyc; waits = 0; acc_cnt++;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clock) begin
    bit ovx, strobe;
    tx_t e;
    ovx    = active && is_normal && (cyc >= acc_cyc + 2*n_tx + waits);
    strobe = avm_read || avm_write;
    check("in_ready", in_ready, rst_ok && !active);
    check("busy", busy, active || (AUTO && !rst_ok));
    check("out_valid", out_valid, ovx);
    if (ovx) check("out_block", out_block, exp_res);
    check("err", err, err_exp);
    err_exp = 1'b0;
    check("chipselect", avm_chipselect, strobe);
    if (avm_read && avm_write) fail("read_and_write");
    if (err) err_cnt++;
    if (out_valid && !ov_prev) ov_rise = cyc;
    ov_prev = out_valid;

    if (!rst_ok) begin
      check("strobe_in_reset", strobe, 1'b0);
    end else if (gap_exp) begin
      check("gap_strobe", strobe, 1'b0);
      gap_exp = 1'b0;
    end else if (strobe) begin
      if (exp_q.size() == 0) begin
        fail("unexpected_request");
      end else begin
        e = exp_q[0];
        check("req_write", avm_write, e.wr);
        check("req_address", avm_address, e.addr);
        if (e.wr) check("req_writedata", avm_writedata, e.data);
        if (held) begin
          check("hold_address", avm_address, held_tx.addr);
          check("hold_writedata", avm_writedata, held_tx.data);
          check("hold_write", avm_write, held_tx.wr);
        end
        if (avm_waitrequest) begin
          waits++;
          held = 1'b1;
          held_tx.wr = avm_write; held_tx.addr = avm_address;
          held_tx.data = avm_writedata; held_tx.last_err = 1'b0;
        end else begin
          held = 1'b0;
          void'(exp_q.pop_front());
          gap_exp = 1'b1;
          err_exp = e.last_err;
          last_tx = e;
          if (!e.wr && e.addr == 8'd2) stat_reads++;
          if (e.wr && e.addr == 8'd3) wr3_q.push_back(avm_writedata);
        end
      end
    end else if (held) begin
      fail("request_dropped_while_stalled");
      held = 1'b0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clock); #2;
  endtask

  task automatic run_block(input logic [127:0] b, input logic [127:0] m,
                           input int pin, input int pout, input bit stall, input int rdelay);
    int t, c0, oc;
    mem[0] = m[127:96]; mem[1] = m[95:64]; mem[2] = m[63:32]; mem[3] = m[31:0];
    plan_in = pin; plan_out = pout; stall_en = stall; stall_cnt = 0;
    c0 = acc_cnt; out_ready = 1'b0;
    in_valid = 1'b1; in_block = b;
    t = 0;
    while (acc_cnt == c0 && t < 50) begin step(); t++; end
    in_valid = 1'b0;
    if (acc_cnt == c0) begin fail("accept_timeout"); return; end
    // in_valid/in_block wiggle while busy: must be ignored, latched block kept
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_block = {$urandom, $urandom, $urandom, $urandom};
      step();
    end
    in_valid = 1'b0;
    t = 0; oc = 0;
    while (active && t < 3000) begin
      if (out_valid) begin
        if (oc >= rdelay) out_ready = 1'b1;
        oc++;
      end
      step(); t++;
    end
    out_ready = 1'b0;
    if (active) fail("block_timeout");
    check("queue_drained", exp_q.size(), 0);
    step();
  endtask

  initial begin
    int t;
    resetn = 1'b0;
    repeat (3) step();
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_strobes", {avm_read, avm_write, avm_chipselect}, 3'b000);
    check("rst_err", err, 1'b0);
    check("rst_busy", busy, AUTO);
    resetn = 1'b1;
    step();
    check("in_ready_after_release", in_ready, !AUTO);
    t = 0;
    while (active && t < 50) begin step(); t++; end
    if (AUTO) check("autostart_cmd", {last_tx.wr, last_tx.addr, last_tx.data}, {1'b1, 8'd1, 32'd3});

    // directed 1: zero-wait, immediate status
    run_block(128'h00112233_44556677_8899AABB_CCDDEEFF,
              128'hA0A1A2A3_B0B1B2B3_C0C1C2C3_D0D1D2D3, 0, 0, 1'b0, 0);
    check("t1_wr_count", wr3_q.size(), 4);
    if (wr3_q.size() == 4) begin
      check("t1_wr0", wr3_q[0], 32'h00112233);
      check("t1_wr1", wr3_q[1], 32'h44556677);
      check("t1_wr2", wr3_q[2], 32'h8899AABB);
      check("t1_wr3", wr3_q[3], 32'hCCDDEEFF);
    end
    check("t1_ov_cycle", ov_rise - acc_cyc + 1, 29);
    check("t1_out_block", exp_res, 128'hA0A1A2A3_B0B1B2B3_C0C1C2C3_D0D1D2D3);

    // directed 2: three failed polls in POLL_OUT
    run_block(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
              128'h11111111_22222222_33333333_44444444, 0, 3, 1'b0, 0);
    check("t2_status_reads", stat_reads, 5);
    check("t2_ov_cycle", ov_rise - acc_cyc + 1, 35);

    // directed 3: status stuck at 0 -> timeout
    run_block(128'h5555AAAA_5555AAAA_5555AAAA_5555AAAA, '0, 100, 0, 1'b0, 0);
    check("t3_status_reads", stat_reads, 4);
    check("t3_err_pulses", err_cnt, 1);
    check("t3_no_out_valid", ov_rise, -1);
    check("t3_last_clear", {last_tx.wr, last_tx.addr, last_tx.data}, {1'b1, 8'd2, 32'd0});

    // directed 4: 3-cycle stall on WR2
    run_block(128'h00112233_44556677_8899AABB_CCDDEEFF,
              128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF, 0, 0, 1'b1, 0);
    check("t4_stall_cycles", stall_cnt, 3);
    check("t4_ov_cycle", ov_rise - acc_cyc + 1, 32);

    // directed 5: consumer holds off 10 cycles
    run_block(128'hFFFF0000_0000FFFF_12345678_9ABCDEF0,
              128'h0F0F0F0F_F0F0F0F0_AAAA5555_5555AAAA, 1, 0, 1'b0, 10);

    // directed 6: reset during RD1
    mem[0] = 32'h1; mem[1] = 32'h2; mem[2] = 32'h3; mem[3] = 32'h4;
    plan_in = 0; plan_out = 0; stall_en = 1'b0;
    in_valid = 1'b1; in_block = 128'hBEEF;
    step();
    in_valid = 1'b0;
    t = 0;
    while (!(avm_read && avm_address == 8'd5) && t < 200) begin step(); t++; end
    if (!(avm_read && avm_address == 8'd5)) fail("rd1_not_reached");
    resetn = 1'b0;
    step();
    check("t6_strobes_after_reset", {avm_read, avm_write, avm_chipselect}, 3'b000);
    step();
    resetn = 1'b1;
    step();
    t = 0;
    while (active && t < 50) begin step(); t++; end
    if (AUTO) check("t6_autostart_cmd", {last_tx.wr, last_tx.addr, last_tx.data}, {1'b1, 8'd1, 32'd3});

    // randomized blocks with random stalls, poll failures and timeouts
    rand_wait = 1'b1;
    for (int n = 0; n < 24; n++) begin
      int pi, po;
      pi = ($urandom_range(0, 6) == 0) ? 9 : int'($urandom_range(0, 3));
      po = ($urandom_range(0, 6) == 0) ? 9 : int'($urandom_range(0, 3));
      run_block({$urandom, $urandom, $urandom, $urandom},
                {$urandom, $urandom, $urandom, $urandom},
                pi, po, 1'b0, int'($urandom_range(0, 3)));
    end
    rand_wait = 1'b0;
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
